// File: rtl/n64_joybus_rx.sv
// Joybus receive front-end: syncs raw SI pins, decodes pulse-width bits on SI clock rises,
// and emits framed bytes with start/end/error strobes.
module n64_joybus_rx #(
    parameter int unsigned ONE_MAX_TICKS = 2,
    parameter int unsigned TIMEOUT_TICKS = 7,
    parameter int unsigned MAX_BYTES     = 15
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_n64_reset,
    input  logic       i_n64_si_clk,
    input  logic       i_n64_si_dq,
    input  logic       i_rx_enable,
    output logic       o_busy,
    output logic       o_frame_start,
    output logic [7:0] o_byte,
    output logic       o_byte_valid,
    output logic [3:0] o_byte_index,
    output logic       o_frame_end,
    output logic [3:0] o_frame_bytes,
    output logic       o_frame_error
);

    localparam logic [2:0] LowOneMax    = 3'(ONE_MAX_TICKS);
    localparam logic [3:0] TimeoutTicks = 4'(TIMEOUT_TICKS);
    localparam logic [3:0] MaxBytes     = 4'(MAX_BYTES);

    typedef enum logic [1:0] {StIdle, StLow, StHigh} state_t;

    state_t     r_state;
    logic [1:0] r_clk_sync;
    logic [1:0] r_dq_sync;
    logic [1:0] r_nrst_sync;
    logic       r_clk_prev;
    logic [2:0] r_low_cnt;
    logic [2:0] r_high_cnt;
    logic [2:0] r_bit_cnt;
    logic [3:0] r_byte_cnt;
    logic [6:0] r_shift;
    logic       r_overflow;

    logic       w_tick;
    logic       w_dq;
    logic       w_run;
    logic       w_bit;
    logic [3:0] w_high_next;

    assign w_tick      = r_clk_sync[1] & ~r_clk_prev;
    assign w_dq        = r_dq_sync[1];
    assign w_run       = r_nrst_sync[1] & i_rx_enable;
    assign w_bit       = (r_low_cnt <= LowOneMax);
    assign w_high_next = {1'b0, r_high_cnt} + 4'd1;
    assign o_busy      = (r_state != StIdle);

    // Synchronisers reset high so the idle line does not look like a falling edge.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_clk_sync  <= 2'b11;
            r_dq_sync   <= 2'b11;
            r_nrst_sync <= 2'b11;
            r_clk_prev  <= 1'b1;
        end else begin
            r_clk_sync  <= {r_clk_sync[0], i_n64_si_clk};
            r_dq_sync   <= {r_dq_sync[0], i_n64_si_dq};
            r_nrst_sync <= {r_nrst_sync[0], i_n64_reset};
            r_clk_prev  <= r_clk_sync[1];
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state       <= StIdle;
            r_low_cnt     <= 3'd0;
            r_high_cnt    <= 3'd0;
            r_bit_cnt     <= 3'd0;
            r_byte_cnt    <= 4'd0;
            r_shift       <= 7'd0;
            r_overflow    <= 1'b0;
            o_frame_start <= 1'b0;
            o_byte        <= 8'd0;
            o_byte_valid  <= 1'b0;
            o_byte_index  <= 4'd0;
            o_frame_end   <= 1'b0;
            o_frame_bytes <= 4'd0;
            o_frame_error <= 1'b0;
        end else begin
            o_frame_start <= 1'b0;
            o_byte_valid  <= 1'b0;
            o_frame_end   <= 1'b0;
            if (!w_run) begin
                // Silent abort: no end strobe, partial byte discarded.
                r_state <= StIdle;
            end else if (w_tick) begin
                case (r_state)
                    StIdle: begin
                        if (!w_dq) begin
                            r_state       <= StLow;
                            o_frame_start <= 1'b1;
                            r_low_cnt     <= 3'd1;
                            r_bit_cnt     <= 3'd0;
                            r_byte_cnt    <= 4'd0;
                            r_overflow    <= 1'b0;
                        end
                    end
                    StLow: begin
                        if (!w_dq) begin
                            r_low_cnt <= (r_low_cnt == 3'd7) ? 3'd7 : r_low_cnt + 3'd1;
                        end else begin
                            r_state    <= StHigh;
                            r_high_cnt <= 3'd1;
                            r_shift    <= {r_shift[5:0], w_bit};
                            r_bit_cnt  <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                if (r_byte_cnt < MaxBytes) begin
                                    o_byte       <= {r_shift, w_bit};
                                    o_byte_valid <= 1'b1;
                                    o_byte_index <= r_byte_cnt;
                                    r_byte_cnt   <= r_byte_cnt + 4'd1;
                                end else begin
                                    r_overflow <= 1'b1;
                                end
                            end
                        end
                    end
                    StHigh: begin
                        if (w_dq) begin
                            if (w_high_next >= TimeoutTicks) begin
                                r_state       <= StIdle;
                                o_frame_end   <= 1'b1;
                                o_frame_bytes <= r_byte_cnt;
                                o_frame_error <= r_overflow | (r_bit_cnt != 3'd1);
                            end else begin
                                r_high_cnt <= w_high_next[2:0];
                            end
                        end else begin
                            r_state   <= StLow;
                            r_low_cnt <= 3'd1;
                        end
                    end
                    default: r_state <= StIdle;
                endcase
            end
        end
    end

endmodule
